// File: rtl/stall_issue.sv
// Issue stage: streams a captured 8-instruction program into the pipeline,
// inserting no-op bubbles on read-after-write hazards and counting them.
module stall_issue (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [63:0] instrMemBits,
  input  logic        out_ready,
  output logic        out_valid,
  output logic [7:0]  out_instr,
  output logic        out_bubble,
  output logic [2:0]  out_slot,
  output logic        busy,
  output logic        done,
  output logic [3:0]  stall_count
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  localparam logic [1:0] OPC_NOOP = 2'b00;
  localparam logic [1:0] OPC_ADD  = 2'b01;
  localparam logic [1:0] OPC_SW   = 2'b10;
  localparam logic [1:0] OPC_LW   = 2'b11;

  logic [1:0] state;
  logic [2:0] pc;
  logic [7:0] imem [8];

  // History of the two most recently accepted words (bubbles never write).
  logic       h1_wr_en;
  logic [2:0] h1_wr_reg;
  logic       h1_is_lw;
  logic       h2_wr_en;
  logic [2:0] h2_wr_reg;
  logic       h2_is_lw;

  logic [7:0] cur_word;
  logic [1:0] cur_opc;
  logic [2:0] cur_a;
  logic [2:0] cur_b;
  logic       reads_a;
  logic       reads_b;
  logic       writes;
  logic       haz_a;
  logic       haz_b;
  logic       hazard;
  logic       accept;
  logic       new_wr_en;
  logic [2:0] new_wr_reg;
  logic       new_is_lw;

  // Decode the instruction at pc and check its source registers against history.
  always_comb begin
    cur_word = imem[pc];
    cur_opc  = cur_word[7:6];
    cur_a    = cur_word[5:3];
    cur_b    = cur_word[2:0];
    reads_a  = (cur_opc == OPC_SW) || (cur_opc == OPC_ADD);
    reads_b  = (cur_opc != OPC_NOOP);
    writes   = (cur_opc == OPC_LW) || (cur_opc == OPC_ADD);
    // H1 blocks any producer; H2 only still blocks a load (one extra beat of latency).
    haz_a    = reads_a &&
               ((h1_wr_en && (h1_wr_reg == cur_a)) ||
                (h2_wr_en && h2_is_lw && (h2_wr_reg == cur_a)));
    haz_b    = reads_b &&
               ((h1_wr_en && (h1_wr_reg == cur_b)) ||
                (h2_wr_en && h2_is_lw && (h2_wr_reg == cur_b)));
    hazard   = (state == ST_ISSUE) && (haz_a || haz_b);
    accept   = (state == ST_ISSUE) && out_ready;
    // History entry for the word offered this cycle.
    new_wr_en  = !hazard && writes;
    new_wr_reg = hazard ? '0 : cur_a;
    new_is_lw  = !hazard && (cur_opc == OPC_LW);
  end

  // Output decode purely from registered state.
  always_comb begin
    out_valid  = (state == ST_ISSUE);
    out_bubble = hazard;
    out_instr  = (out_valid && !hazard) ? cur_word : '0;
    out_slot   = pc;
    busy       = (state == ST_ISSUE);
    done       = (state == ST_DONE);
  end

  // Sequencer: program capture, issue handshakes, history and bubble count.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      pc          <= '0;
      h1_wr_en    <= 1'b0;
      h1_wr_reg   <= '0;
      h1_is_lw    <= 1'b0;
      h2_wr_en    <= 1'b0;
      h2_wr_reg   <= '0;
      h2_is_lw    <= 1'b0;
      stall_count <= '0;
      for (int unsigned i = 0; i < 8; i++) begin
        imem[i] <= '0;
      end
    end else begin
      case (state)
        ST_IDLE: begin
          if (load) begin
            for (int unsigned i = 0; i < 8; i++) begin
              imem[i] <= instrMemBits[(7 - i) * 8 +: 8];
            end
            pc          <= '0;
            h1_wr_en    <= 1'b0;
            h1_wr_reg   <= '0;
            h1_is_lw    <= 1'b0;
            h2_wr_en    <= 1'b0;
            h2_wr_reg   <= '0;
            h2_is_lw    <= 1'b0;
            stall_count <= '0;
            state       <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (accept) begin
            h2_wr_en  <= h1_wr_en;
            h2_wr_reg <= h1_wr_reg;
            h2_is_lw  <= h1_is_lw;
            h1_wr_en  <= new_wr_en;
            h1_wr_reg <= new_wr_reg;
            h1_is_lw  <= new_is_lw;
            if (hazard) begin
              if (stall_count != 4'hF) begin
                stall_count <= stall_count + 4'd1;
              end
            end else begin
              pc <= pc + 3'd1;
              if (pc == 3'd7) begin
                state <= ST_DONE;
              end
            end
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_stall_issue.sv
// Self-checking bench for stall_issue: per-cycle comparison against a
// register-readiness model, directed program streams and random traffic.
module tb_stall_issue;

  logic        clk = 1'b0;
  logic        rst;
  logic        load;
  logic [63:0] instrMemBits;
  logic        out_ready;
  logic        out_valid;
  logic [7:0]  out_instr;
  logic        out_bubble;
  logic [2:0]  out_slot;
  logic        busy;
  logic        done;
  logic [3:0]  stall_count;

  stall_issue dut (
    .clk          (clk),
    .rst          (rst),
    .load         (load),
    .instrMemBits (instrMemBits),
    .out_ready    (out_ready),
    .out_valid    (out_valid),
    .out_instr    (out_instr),
    .out_bubble   (out_bubble),
    .out_slot     (out_slot),
    .busy         (busy),
    .done         (done),
    .stall_count  (stall_count)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  // Model: phase 0 idle, 1 issuing, 2 done. A register written at issue beat n
  // becomes readable at beat n+2 (add) or n+3 (lw).
  int         m_state = 0;
  int         m_pc = 0;
  int         m_beat = 0;
  int         m_stall = 0;
  logic [7:0] m_prog [8];
  int         m_ready_at [8];

  logic [8:0] acc_q [$];
  logic [8:0] exp_q [$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  function automatic bit m_hazard();
    logic [7:0] w;
    logic [1:0] opc;
    int ra;
    int rb;
    bit h;
    if (m_state != 1) return 1'b0;
    w   = m_prog[m_pc];
    opc = w[7:6];
    ra  = int'(w[5:3]);
    rb  = int'(w[2:0]);
    h   = 1'b0;
    if (opc != 2'b00 && m_ready_at[rb] > m_beat) h = 1'b1;
    if ((opc == 2'b10 || opc == 2'b01) && m_ready_at[ra] > m_beat) h = 1'b1;
    return h;
  endfunction

  task automatic m_clear();
    m_pc = 0;
    m_beat = 0;
    m_stall = 0;
    for (int i = 0; i < 8; i++) m_ready_at[i] = 0;
  endtask

  // Compare outputs against the model, log accepted words, then advance the model
  // with the inputs that the next rising edge will sample.
  always @(negedge clk) begin
    bit         hz;
    logic [7:0] w;
    hz = m_hazard();
    if (chk_en) begin
      chk("out_valid", out_valid, m_state == 1);
      chk("out_bubble", out_bubble, hz);
      chk("out_instr", out_instr, (m_state == 1 && !hz) ? m_prog[m_pc] : 8'h00);
      chk("out_slot", out_slot, m_pc[2:0]);
      chk("busy", busy, m_state == 1);
      chk("done", done, m_state == 2);
      chk("stall_count", stall_count, m_stall[3:0]);
    end
    if (out_valid === 1'b1 && out_ready === 1'b1) acc_q.push_back({out_bubble, out_instr});
    if (rst) begin
      m_state = 0;
      m_clear();
      for (int i = 0; i < 8; i++) m_prog[i] = 8'h00;
    end else begin
      case (m_state)
        0: if (load) begin
          for (int i = 0; i < 8; i++) m_prog[i] = instrMemBits[(7 - i) * 8 +: 8];
          m_clear();
          m_state = 1;
        end
        1: if (out_ready) begin
          if (hz) begin
            if (m_stall < 15) m_stall++;
          end else begin
            w = m_prog[m_pc];
            if (w[7:6] == 2'b11) m_ready_at[w[5:3]] = m_beat + 3;
            if (w[7:6] == 2'b01) m_ready_at[w[5:3]] = m_beat + 2;
            if (m_pc == 7) m_state = 2;
            m_pc = (m_pc + 1) % 8;
          end
          m_beat++;
        end
        default: m_state = 0;
      endcase
    end
  end

  task automatic do_load(input logic [63:0] p);
    @(posedge clk);
    #2;
    acc_q.delete();
    instrMemBits = p;
    load = 1'b1;
    @(posedge clk);
    #2;
    load = 1'b0;
  endtask

  task automatic run_until_done(output int cycles);
    cycles = 0;
    do begin
      @(negedge clk);
      cycles++;
    end while (done !== 1'b1 && cycles < 200);
    chk("done_seen", done, 1'b1);
  endtask

  task automatic check_stream(input string name, input int exp_stall);
    chk({name, "_len"}, acc_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < acc_q.size(); i++)
      chk($sformatf("%s[%0d]", name, i), acc_q[i], exp_q[i]);
    chk({name, "_stall"}, stall_count, exp_stall);
  endtask

  task automatic wait_slot(input logic [2:0] s);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (out_slot !== s && n < 100);
    chk("wait_slot", out_slot, s);
  endtask

  task automatic exp_lw_add();
    exp_q = '{9'h0D9, 9'h100, 9'h100, 9'h063, 9'h000, 9'h000, 9'h000, 9'h000, 9'h000, 9'h000};
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: actual timeout required finish");
    $fatal(1);
  end

  initial begin
    int         cyc;
    int         dn;
    logic [7:0] b;
    logic [63:0] p;
    rst = 1'b1;
    load = 1'b0;
    out_ready = 1'b0;
    instrMemBits = '0;
    repeat (2) @(posedge clk);
    #2;
    chk_en = 1'b1;
    @(negedge clk);
    chk("rst_valid", out_valid, 1'b0);
    chk("rst_slot", out_slot, 3'd0);
    chk("rst_stall", stall_count, 4'd0);
    chk("rst_done", done, 1'b0);
    @(posedge clk);
    #2;
    rst = 1'b0;
    out_ready = 1'b1;

    // All noops: 8 accepts, done in the ninth cycle after the load edge.
    do_load(64'h0);
    run_until_done(cyc);
    chk("noop_done_cycle", cyc, 9);
    exp_q = '{9'h000, 9'h000, 9'h000, 9'h000, 9'h000, 9'h000, 9'h000, 9'h000};
    check_stream("noops", 0);

    do_load(64'hD963_0000_0000_0000);
    run_until_done(cyc);
    exp_lw_add();
    check_stream("lw_add", 2);

    do_load(64'h4A88_0000_0000_0000);
    run_until_done(cyc);
    exp_q = '{9'h04A, 9'h100, 9'h088, 9'h000, 9'h000, 9'h000, 9'h000, 9'h000, 9'h000};
    check_stream("add_sw", 1);

    do_load(64'hD900_6300_0000_0000);
    run_until_done(cyc);
    exp_q = '{9'h0D9, 9'h000, 9'h100, 9'h063, 9'h000, 9'h000, 9'h000, 9'h000, 9'h000};
    check_stream("lw_noop_add", 1);

    // Backpressure while a bubble is offered.
    do_load(64'hD963_0000_0000_0000);
    @(posedge clk);
    #2;
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_instr", out_instr, 8'h00);
      chk("bp_bubble", out_bubble, 1'b1);
      chk("bp_stall", stall_count, 4'd0);
      chk("bp_slot", out_slot, 3'd1);
    end
    @(posedge clk);
    #2;
    out_ready = 1'b1;
    run_until_done(cyc);
    exp_lw_add();
    check_stream("bp", 2);

    // Ignored load mid-program, then abort at pc 4 and restart.
    do_load(64'h0102_0304_0506_0708);
    wait_slot(3'd1);
    @(posedge clk);
    #2;
    instrMemBits = '1;
    load = 1'b1;
    @(posedge clk);
    #2;
    load = 1'b0;
    instrMemBits = '0;
    @(negedge clk);
    chk("ign_slot", out_slot, 3'd3);
    chk("ign_instr", out_instr, 8'h04);
    @(posedge clk);
    #2;
    rst = 1'b1;
    @(negedge clk);
    chk("pre_rst_slot", out_slot, 3'd4);
    chk("pre_rst_instr", out_instr, 8'h05);
    @(posedge clk);
    #2;
    rst = 1'b0;
    @(negedge clk);
    chk("abort_valid", out_valid, 1'b0);
    chk("abort_instr", out_instr, 8'h00);
    chk("abort_bubble", out_bubble, 1'b0);
    chk("abort_slot", out_slot, 3'd0);
    chk("abort_busy", busy, 1'b0);
    chk("abort_stall", stall_count, 4'd0);
    dn = 0;
    for (int i = 0; i < 5; i++) begin
      if (done === 1'b1) dn++;
      @(negedge clk);
    end
    chk("abort_no_done", dn, 0);
    do_load(64'hD963_0000_0000_0000);
    run_until_done(cyc);
    exp_lw_add();
    check_stream("restart", 2);

    // Random traffic: backpressure, loads at any time, rare resets.
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk);
      #2;
      out_ready = ($urandom_range(0, 3) != 0);
      rst = ($urandom_range(0, 149) == 0);
      load = ($urandom_range(0, 7) == 0);
      for (int i = 0; i < 8; i++) begin
        b = 8'($urandom);
        if ($urandom_range(0, 1) == 1) b = b & 8'hDB;
        p[i * 8 +: 8] = b;
      end
      instrMemBits = p;
    end
    @(posedge clk);
    #2;
    rst = 1'b0;
    load = 1'b0;
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
